// File: rtl/cond_exmem_stage.sv
// rtl/cond_exmem_stage.sv - execute-stage condition unit, NZCV flags register and EX/MEM pipeline register
//
// Purpose:
//   Holds the architectural NZCV flags, evaluates the 4-bit condition of the
//   instruction in E against them, gates that instruction's side effects
//   (register write, memory write, PC redirect, flag update) and registers the
//   surviving results into the memory stage.
//
// Configuration macro:
//   COND_EXEC_EN  defined   -> full ARM-style condition decode
//                 undefined -> every condition passes (CondExE = 1)
//
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   ALUResultE, ALUFlags, WriteDataE  ALU result, ALU flags {N,Z,C,V}, store data
//   WA3E, CondE, FlagWriteE           destination index, condition, flag-group write
//   RegWriteE, MemWriteE, MemtoRegE,
//   PCSrcE                            ungated control from decode
//   StallE, FlushE                    hazard-unit stall / kill of E
//   CondExE, BranchTakenE             combinational condition pass / taken branch
//   FlagsQ                            current flags register
//   ALUResultM, WriteDataM, WA3M,
//   RegWriteM, MemWriteM, MemtoRegM,
//   PCSrcM                            registered EX/MEM outputs

module cond_exmem_stage #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [BITS-1:0] ALUResultE,
  input  logic [3:0]      ALUFlags,
  input  logic [BITS-1:0] WriteDataE,
  input  logic [3:0]      WA3E,
  input  logic [3:0]      CondE,
  input  logic [1:0]      FlagWriteE,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            MemtoRegE,
  input  logic            PCSrcE,
  input  logic            StallE,
  input  logic            FlushE,
  output logic            CondExE,
  output logic            BranchTakenE,
  output logic [3:0]      FlagsQ,
  output logic [BITS-1:0] ALUResultM,
  output logic [BITS-1:0] WriteDataM,
  output logic [3:0]      WA3M,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic            MemtoRegM,
  output logic            PCSrcM
);

  logic [3:0] flags_q;
  logic       flag_n, flag_z, flag_c, flag_v;
  logic       cond_ex;
  logic       we_nz, we_cv;

  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];

`ifdef COND_EXEC_EN
  always_comb begin
    cond_ex = 1'b1;
    case (CondE)
      4'b0000: cond_ex = flag_z;                              // EQ
      4'b0001: cond_ex = ~flag_z;                             // NE
      4'b0010: cond_ex = flag_c;                              // CS
      4'b0011: cond_ex = ~flag_c;                             // CC
      4'b0100: cond_ex = flag_n;                              // MI
      4'b0101: cond_ex = ~flag_n;                             // PL
      4'b0110: cond_ex = flag_v;                              // VS
      4'b0111: cond_ex = ~flag_v;                             // VC
      4'b1000: cond_ex = flag_c & ~flag_z;                    // HI
      4'b1001: cond_ex = ~flag_c | flag_z;                    // LS
      4'b1010: cond_ex = (flag_n == flag_v);                  // GE
      4'b1011: cond_ex = (flag_n != flag_v);                  // LT
      4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);        // GT
      4'b1101: cond_ex = flag_z | (flag_n != flag_v);         // LE
      default: cond_ex = 1'b1;                                // AL and 1111
    endcase
  end
`else
  // Condition field ignored: every instruction executes. The flags are still
  // kept so that software observing FlagsQ sees the same register behaviour.
  logic unused_cond;
  assign unused_cond = ^{CondE, flag_n, flag_z, flag_c, flag_v};
  assign cond_ex     = 1'b1;
`endif

  assign CondExE      = cond_ex;
  assign BranchTakenE = PCSrcE & cond_ex & ~FlushE;

  // A stalled instruction must not touch the flags until the cycle it leaves
  // E, otherwise a multi-cycle stall would write them more than once.
  assign we_nz = FlagWriteE[1] & cond_ex & ~FlushE & ~StallE;
  assign we_cv = FlagWriteE[0] & cond_ex & ~FlushE & ~StallE;

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else begin
      if (we_nz) flags_q[3:2] <= ALUFlags[3:2];
      if (we_cv) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

  assign FlagsQ = flags_q;

  // EX/MEM register: reset > stall > flush > normal. Stall beats flush so a
  // held instruction is only killed when it is presented again unstalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      ALUResultM <= '0;
      WriteDataM <= '0;
      WA3M       <= 4'd0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      PCSrcM     <= 1'b0;
    end else if (StallE) begin
      ALUResultM <= ALUResultM;
      WriteDataM <= WriteDataM;
      WA3M       <= WA3M;
      RegWriteM  <= RegWriteM;
      MemWriteM  <= MemWriteM;
      MemtoRegM  <= MemtoRegM;
      PCSrcM     <= PCSrcM;
    end else if (FlushE) begin
      // Bubble: data still loads since the controls make it irrelevant.
      ALUResultM <= ALUResultE;
      WriteDataM <= WriteDataE;
      WA3M       <= WA3E;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      PCSrcM     <= 1'b0;
    end else begin
      ALUResultM <= ALUResultE;
      WriteDataM <= WriteDataE;
      WA3M       <= WA3E;
      RegWriteM  <= RegWriteE & cond_ex;
      MemWriteM  <= MemWriteE & cond_ex;
      MemtoRegM  <= MemtoRegE;
      PCSrcM     <= PCSrcE & cond_ex;
    end
  end

endmodule

// File: tb/tb_cond_exmem_stage.sv
// tb/tb_cond_exmem_stage.sv - self-checking bench for cond_exmem_stage
module tb_cond_exmem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALUResultE, WriteDataE;
  logic [3:0]  ALUFlags, WA3E, CondE;
  logic [1:0]  FlagWriteE;
  logic        RegWriteE, MemWriteE, MemtoRegE, PCSrcE, StallE, FlushE;
  logic        CondExE, BranchTakenE;
  logic [3:0]  FlagsQ;
  logic [31:0] ALUResultM, WriteDataM;
  logic [3:0]  WA3M;
  logic        RegWriteM, MemWriteM, MemtoRegM, PCSrcM;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [3:0]  wa3;
    logic        rw, mw, m2r, pcs;
    logic        data_ok;
    logic [3:0]  flags;
  } exp_t;

  exp_t        sb[$];
  exp_t        mstate;
  logic [3:0]  mflags;

  cond_exmem_stage #(.BITS(32)) dut (
    .clk(clk), .reset(reset),
    .ALUResultE(ALUResultE), .ALUFlags(ALUFlags), .WriteDataE(WriteDataE),
    .WA3E(WA3E), .CondE(CondE), .FlagWriteE(FlagWriteE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
    .PCSrcE(PCSrcE), .StallE(StallE), .FlushE(FlushE),
    .CondExE(CondExE), .BranchTakenE(BranchTakenE), .FlagsQ(FlagsQ),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WA3M(WA3M),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
    .PCSrcM(PCSrcM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
`ifdef COND_EXEC_EN
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
`else
    return (c === c) && (f === f);
`endif
  endfunction

  // Drive is done by the caller; this checks the combinational outputs,
  // pushes the expected M state, clocks once and compares.
  task automatic step(input string tag);
    logic  ce;
    exp_t  e;
    #1;
    ce = ref_cond(CondE, mflags);
    chk({tag, ":cond"}, CondExE, ce);
    chk({tag, ":btaken"}, BranchTakenE, PCSrcE & ce & ~FlushE);
    if (reset) begin
      e = '{alu: 0, wd: 0, wa3: 0, rw: 0, mw: 0, m2r: 0, pcs: 0, data_ok: 1, flags: 0};
    end else if (StallE) begin
      e = mstate;
      e.flags = mflags;
    end else begin
      e.alu = ALUResultE; e.wd = WriteDataE; e.wa3 = WA3E;
      e.data_ok = !FlushE;
      e.rw  = !FlushE && RegWriteE && ce;
      e.mw  = !FlushE && MemWriteE && ce;
      e.pcs = !FlushE && PCSrcE && ce;
      e.m2r = !FlushE && MemtoRegE;
      e.flags = mflags;
      if (!FlushE && ce && FlagWriteE[1]) e.flags[3:2] = ALUFlags[3:2];
      if (!FlushE && ce && FlagWriteE[0]) e.flags[1:0] = ALUFlags[1:0];
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ":sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      if (e.data_ok) begin
        chk({tag, ":alu"}, ALUResultM, e.alu);
        chk({tag, ":wd"},  WriteDataM, e.wd);
        chk({tag, ":wa3"}, WA3M, e.wa3);
      end
      chk({tag, ":rw"},    RegWriteM, e.rw);
      chk({tag, ":mw"},    MemWriteM, e.mw);
      chk({tag, ":m2r"},   MemtoRegM, e.m2r);
      chk({tag, ":pcs"},   PCSrcM, e.pcs);
      chk({tag, ":flags"}, FlagsQ, e.flags);
      mstate = e;
      mflags = e.flags;
    end
  endtask

  task automatic idle();
    reset = 0; ALUResultE = 0; WriteDataE = 0; ALUFlags = 0; WA3E = 0;
    CondE = 4'hE; FlagWriteE = 0; RegWriteE = 0; MemWriteE = 0;
    MemtoRegE = 0; PCSrcE = 0; StallE = 0; FlushE = 0;
  endtask

  initial begin
    mflags = 0;
    mstate = '{alu: 0, wd: 0, wa3: 0, rw: 0, mw: 0, m2r: 0, pcs: 0, data_ok: 0, flags: 0};
    idle();
    ALUResultE = 32'h1234_5678; RegWriteE = 1; MemWriteE = 1; PCSrcE = 1;

    // Reset
    reset = 1; step("reset");
    chk("reset_flags", FlagsQ, 4'b0000);
    chk("reset_alu", ALUResultM, 32'h0);
    chk("reset_rw", RegWriteM, 1'b0);

    // Flag write, then EQ passes
    idle(); ALUFlags = 4'b0100; FlagWriteE = 2'b11; ALUResultE = 32'h11;
    step("fwrite");
    chk("fwrite_flags", FlagsQ, 4'b0100);
    idle(); CondE = 4'b0000; RegWriteE = 1; WA3E = 4'd3; ALUResultE = 32'h22;
    #1 chk("eq_cond", CondExE, 1'b1);
    step("eq");
    chk("eq_rw", RegWriteM, 1'b1);

    // Condition fail (NE with Z=1)
    idle(); CondE = 4'b0001; MemWriteE = 1; FlagWriteE = 2'b11; ALUFlags = 4'b1000;
    WriteDataE = 32'hDEAD_BEEF;
`ifdef COND_EXEC_EN
    #1 chk("ne_cond", CondExE, 1'b0);
`endif
    step("ne_fail");
`ifdef COND_EXEC_EN
    chk("ne_mw", MemWriteM, 1'b0);
    chk("ne_flags", FlagsQ, 4'b0100);
`endif

    // Partial write from cleared flags, then GE
    idle(); reset = 1; step("reset2");
    idle(); ALUFlags = 4'b1111; FlagWriteE = 2'b01; step("partial");
    chk("partial_flags", FlagsQ, 4'b0011);
    idle(); CondE = 4'b1010; RegWriteE = 1; step("ge");

    // Stall twice, flush, stall+flush, then release
    idle(); ALUResultE = 32'hAA; FlagWriteE = 2'b11; ALUFlags = 4'b1010;
    RegWriteE = 1; StallE = 1;
    step("stall1");
    step("stall2");
    StallE = 0; FlushE = 1; step("flush");
    chk("flush_rw", RegWriteM, 1'b0);
    StallE = 1; FlushE = 1; step("stall_flush");
    StallE = 0; FlushE = 0; step("release");
    chk("release_alu", ALUResultM, 32'hAA);
    chk("release_flags", FlagsQ, 4'b1010);

    // Branch HI with flags 0010
    idle(); ALUFlags = 4'b0010; FlagWriteE = 2'b11; step("setc");
    idle(); CondE = 4'b1000; PCSrcE = 1;
    #1 chk("hi_btaken", BranchTakenE, 1'b1);
    step("hi");
    chk("hi_pcs", PCSrcM, 1'b1);
    FlushE = 1;
    #1 chk("hi_flush_btaken", BranchTakenE, 1'b0);
    step("hi_flush");
    chk("hi_flush_pcs", PCSrcM, 1'b0);

    // Reset while a stalled instruction is held
    idle(); RegWriteE = 1; ALUResultE = 32'h55; step("pre_hold");
    StallE = 1; reset = 1; step("reset_in_stall");
    chk("rst_stall_rw", RegWriteM, 1'b0);

`ifndef COND_EXEC_EN
    idle(); CondE = 4'b0000;
    #1 chk("nocond_eq", CondExE, 1'b1);
`endif

    // Random mix
    for (int i = 0; i < 60; i++) begin
      idle();
      reset      = ($urandom_range(0, 19) == 0);
      ALUResultE = $urandom; WriteDataE = $urandom;
      ALUFlags   = 4'($urandom); WA3E = 4'($urandom); CondE = 4'($urandom);
      FlagWriteE = 2'($urandom);
      RegWriteE  = 1'($urandom); MemWriteE = 1'($urandom);
      MemtoRegE  = 1'($urandom); PCSrcE = 1'($urandom);
      StallE     = ($urandom_range(0, 3) == 0);
      FlushE     = ($urandom_range(0, 4) == 0);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cond_exmem_stage.md
# cond_exmem_stage

Execute-stage condition unit and EX/MEM pipeline register, directly downstream of the ALU. Holds the architectural NZCV flags register, evaluates each instruction's 4-bit condition against it, gates the instruction's side effects (register write, memory write, PC redirect, flag update) and registers the surviving results into the memory stage. Stall and flush inputs come from the hazard unit.

## Interface
- BITS, 32, datapath width of ALU result and store data
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- ALUResultE  input  BITS  ALU result of the instruction in E
- ALUFlags  input  4  ALU flags {N,Z,C,V}, bit 3 = N, bit 0 = V
- WriteDataE  input  BITS  store data from register file/forwarding
- WA3E  input  4  destination register index
- CondE  input  4  ARM-style condition field
- FlagWriteE  input  2  [1] updates N,Z; [0] updates C,V
- RegWriteE, MemWriteE, MemtoRegE, PCSrcE  input  1 each  ungated control from decode
- StallE  input  1  hold E and M; no state change
- FlushE  input  1  kill the instruction in E
- CondExE  output  1  condition passed (combinational)
- BranchTakenE  output  1  PCSrcE & CondExE & ~FlushE (combinational)
- FlagsQ  output  4  current flags register {N,Z,C,V}
- ALUResultM, WriteDataM  output  BITS  registered data
- WA3M  output  4  registered destination
- RegWriteM, MemWriteM, MemtoRegM, PCSrcM  output  1 each  registered gated control

## Operation
- Condition decode against FlagsQ (N,Z,C,V): 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V; 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 treated as 1.
- Effective write enable per flag group: FlagWriteE[i] & CondExE & ~FlushE & ~StallE & ~reset.
- N,Z loaded from ALUFlags[3:2] when group 1 enabled; C,V from ALUFlags[1:0] when group 0 enabled; groups independent.
- EX/MEM register, priority reset > StallE > FlushE > normal:
  - reset: all M outputs 0.
  - StallE: all M outputs hold.
  - FlushE: bubble — RegWriteM, MemWriteM, PCSrcM, MemtoRegM = 0; data/WA3M loaded (don't-care).
  - normal: data and WA3M loaded; RegWriteM = RegWriteE & CondExE, MemWriteM = MemWriteE & CondExE, PCSrcM = PCSrcE & CondExE, MemtoRegM = MemtoRegE.
- StallE and FlushE together: stall wins; the instruction is killed when it is presented again without StallE.

## Timing
- CondExE, BranchTakenE: combinational from CondE, PCSrcE, FlushE and FlagsQ, same cycle.
- Flags visible on FlagsQ one cycle after the writing instruction's enabled E cycle; the next instruction in E sees the updated value (no combinational flag bypass).
- M outputs: one-cycle latency from E inputs.
- Reset values: FlagsQ = 4'b0000, all M outputs 0; reset mid-stall discards the held instruction.
- A flag-setting instruction under stall writes flags exactly once, on the cycle it leaves E.

## Configuration
- COND_EXEC_EN defined: full condition decode as above.
- COND_EXEC_EN undefined: CondExE tied to 1 for every CondE; flags register, FlagWriteE handling, stall/flush behaviour unchanged.

## Test plan
- Reset: assert reset 1 cycle -> FlagsQ = 0000, RegWriteM = MemWriteM = PCSrcM = 0, ALUResultM = 0.
- Flag write: ALUFlags = 0100, FlagWriteE = 11, CondE = 1110 -> next cycle FlagsQ = 0100; then CondE = 0000 (EQ), RegWriteE = 1 -> CondExE = 1, RegWriteM = 1.
- Condition fail: FlagsQ = 0100, CondE = 0001 (NE), MemWriteE = 1, FlagWriteE = 11, ALUFlags = 1000 -> CondExE = 0, MemWriteM = 0, FlagsQ stays 0100.
- Partial write: FlagsQ = 0000, ALUFlags = 1111, FlagWriteE = 01 -> FlagsQ = 0011; then CondE = 1010 (GE) -> CondExE = 0 (N=0, V=1).
- Stall/flush: ALUResultE = 0x0000_00AA, FlagWriteE = 11, StallE = 1 for 2 cycles -> M outputs and FlagsQ hold; StallE = 0, FlushE = 1 -> RegWriteM = 0, FlagsQ unchanged; StallE = FlushE = 1 -> M holds.
- Branch: FlagsQ = 0010, CondE = 1000 (HI), PCSrcE = 1 -> BranchTakenE = 1, PCSrcM = 1 next cycle; with FlushE = 1 -> BranchTakenE = 0, PCSrcM = 0. Without COND_EXEC_EN, CondE = 0000 with FlagsQ = 0000 -> CondExE = 1.
